// File: rtl/qos_wrr_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : qos_wrr_pkg
//  Description : Shared types for the QoS weighted round-robin stage.
//                qos_state_e - control FSM state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package qos_wrr_pkg;

  // Control FSM states.
  typedef enum logic [1:0] {
    ST_INIT_WAIT = 2'd0,
    ST_INIT      = 2'd1,
    ST_IDLE      = 2'd2,
    ST_ACTIVE    = 2'd3
  } qos_state_e;

endpackage
`default_nettype wire

// File: rtl/qos_wrr_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : qos_wrr_fifo
//  Description : Single-clock FIFO for one virtual channel, depth 1<<DEPTH_LOG2.
//                The caller never writes when full or reads when empty.
//  Ports       : clk, rst       - clock, synchronous active-high reset
//                wr_en/wr_data  - push a word
//                rd_en/rd_data  - pop the head word (rd_data shows the head)
//                flush          - empty the FIFO
//                buf_full, buf_empty, fifo_counter - occupancy status
//  Revision    : 1.0 - initial release
// ============================================================================
module qos_wrr_fifo #(
  parameter int DATA_WIDTH = 4,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  flush,
  output logic                  buf_full,
  output logic                  buf_empty,
  output logic [DEPTH_LOG2:0]   fifo_counter
);

  localparam int                DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q;
  logic [DEPTH_LOG2-1:0] rd_ptr_q;
  logic [DEPTH_LOG2:0]   cnt_q;

  // Storage carries no reset; only the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (rd_en) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      cnt_q <= cnt_q + (DEPTH_LOG2+1)'(wr_en) - (DEPTH_LOG2+1)'(rd_en);
    end
  end

  assign rd_data      = mem_q[rd_ptr_q];
  assign buf_full     = (cnt_q == FULL_CNT);
  assign buf_empty    = (cnt_q == '0);
  assign fifo_counter = cnt_q;

endmodule
`default_nettype wire

// File: rtl/qos_wrr.sv
`default_nettype none
// ============================================================================
//  Module      : qos_wrr
//  Description : QoS stage. Demultiplexes input words into NUM_VC FIFOs and
//                drains them through a weighted round-robin arbiter into a
//                registered output stage with valid/ready handshake.
//                Per-VC flow control: pausa (level, hysteresis), continue_qos
//                (pulse), error_full (sticky overflow).
//  Ports       : clk, rst, enb, init           - control
//                umbral_alto/bajo, weights     - config, latched in INIT
//                in_valid, vc_id, input_qos    - input word
//                out_ready, output_qos, out_valid, out_vc - output stream
//                error_full, pausa, continue_qos, idle_qos - status
//  Revision    : 1.0 - initial release
// ============================================================================
module qos_wrr
  import qos_wrr_pkg::*;
#(
  parameter int DATA_WIDTH = 4,
  parameter int NUM_VC     = 4,
  parameter int VC_BITS    = 2,
  parameter int DEPTH_LOG2 = 3,
  parameter int WEIGHT_W   = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enb,
  input  logic                         init,
  input  logic [DEPTH_LOG2:0]          umbral_alto,
  input  logic [DEPTH_LOG2:0]          umbral_bajo,
  input  logic [NUM_VC*WEIGHT_W-1:0]   weights,
  input  logic                         in_valid,
  input  logic [VC_BITS-1:0]           vc_id,
  input  logic [DATA_WIDTH-1:0]        input_qos,
  input  logic                         out_ready,
  output logic [DATA_WIDTH-1:0]        output_qos,
  output logic                         out_valid,
  output logic [VC_BITS-1:0]           out_vc,
  output logic [NUM_VC-1:0]            error_full,
  output logic [NUM_VC-1:0]            pausa,
  output logic [NUM_VC-1:0]            continue_qos,
  output logic                         idle_qos
);

  localparam int               CW       = DEPTH_LOG2 + 1;
  localparam logic [VC_BITS:0] NUM_VC_L = (VC_BITS+1)'(NUM_VC);
  localparam logic [VC_BITS-1:0] LAST_VC = VC_BITS'(NUM_VC - 1);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  qos_state_e                  state_q, state_d;
  logic [CW-1:0]               alto_q, bajo_q;
  logic [NUM_VC*WEIGHT_W-1:0]  weights_q;
  logic [DATA_WIDTH-1:0]       out_data_q;
  logic                        out_valid_q;
  logic [VC_BITS-1:0]          out_vc_q;
  logic [VC_BITS-1:0]          ptr_q, ptr_d;
  logic [WEIGHT_W-1:0]         credit_q, credit_d;
  logic [NUM_VC-1:0]           err_q, pausa_q, cont_q;

  // --------------------------------------------------------------------------
  // Per-VC wires
  // --------------------------------------------------------------------------
  logic [NUM_VC-1:0]           full, empty, wr_en, rd_en, drop_full;
  logic [NUM_VC-1:0]           pausa_d, cont_d;
  logic [CW-1:0]               cnt     [NUM_VC];
  logic [CW-1:0]               cnt_nxt [NUM_VC];
  logic [DATA_WIDTH-1:0]       head    [NUM_VC];

  logic                        init_act, run, vc_ok, push_req, pop_slot, pop;
  logic                        grant_vld, g_empties, all_empty;
  logic [VC_BITS-1:0]          grant;
  logic [WEIGHT_W-1:0]         w_g, cred_eff;
  logic [DATA_WIDTH-1:0]       head_g;

  // init overrides enb: configuration and flush happen whenever init is
  // asserted or the FSM sits in INIT.
  assign init_act  = init | (state_q == ST_INIT);
  assign run       = enb & ~init_act & ((state_q == ST_IDLE) | (state_q == ST_ACTIVE));
  assign vc_ok     = ({1'b0, vc_id} < NUM_VC_L);
  assign push_req  = run & in_valid & vc_ok;
  assign pop_slot  = run & (out_ready | ~out_valid_q);
  assign pop       = pop_slot & grant_vld;
  assign all_empty = &empty;

  // --------------------------------------------------------------------------
  // Per-VC FIFOs and flow-control flags
  // --------------------------------------------------------------------------
  for (genvar i = 0; i < NUM_VC; i++) begin : g_vc
    logic sel;
    assign sel          = (vc_id == VC_BITS'(i));
    // Full is judged on the pre-cycle count; a same-cycle pop does not help.
    assign wr_en[i]     = push_req & sel & ~full[i];
    assign drop_full[i] = push_req & sel &  full[i];
    assign rd_en[i]     = pop & (grant == VC_BITS'(i));
    assign cnt_nxt[i]   = cnt[i] + CW'(wr_en[i]) - CW'(rd_en[i]);

    // Hysteresis: once set, pausa holds until the count falls to umbral_bajo.
    assign pausa_d[i]   = (cnt_nxt[i] >= alto_q) | (pausa_q[i] & (cnt_nxt[i] > bajo_q));
    assign cont_d[i]    = pausa_q[i] & (cnt_nxt[i] <= bajo_q);

    qos_wrr_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
      .clk          (clk),
      .rst          (rst),
      .wr_en        (wr_en[i]),
      .wr_data      (input_qos),
      .rd_en        (rd_en[i]),
      .rd_data      (head[i]),
      .flush        (init_act),
      .buf_full     (full[i]),
      .buf_empty    (empty[i]),
      .fifo_counter (cnt[i])
    );
  end

  // --------------------------------------------------------------------------
  // WRR grant: stay on the pointer VC while it has data, otherwise take the
  // first non-empty VC after it in cyclic order.
  // --------------------------------------------------------------------------
  always_comb begin
    int idx;
    idx       = 0;
    grant_vld = 1'b0;
    grant     = ptr_q;
    if (!empty[ptr_q]) begin
      grant_vld = 1'b1;
    end else begin
      for (int k = 1; k < NUM_VC; k++) begin
        idx = int'(ptr_q) + k;
        if (idx >= NUM_VC) begin
          idx = idx - NUM_VC;
        end
        if (!grant_vld && !empty[VC_BITS'(idx)]) begin
          grant_vld = 1'b1;
          grant     = VC_BITS'(idx);
        end
      end
    end
  end

  // Attributes of the granted VC.
  always_comb begin
    w_g       = '0;
    g_empties = 1'b0;
    head_g    = '0;
    for (int i = 0; i < NUM_VC; i++) begin
      if (grant == VC_BITS'(i)) begin
        w_g       = weights_q[i*WEIGHT_W +: WEIGHT_W];
        g_empties = (cnt_nxt[i] == '0);
        head_g    = head[i];
      end
    end
  end

  // credit_q counts pops already granted to ptr_q in its current turn. A turn
  // ends after weight+1 pops or when the VC drains; only real pops move it.
  always_comb begin
    ptr_d    = ptr_q;
    credit_d = credit_q;
    cred_eff = (grant == ptr_q) ? credit_q : '0;
    if (pop) begin
      if ((cred_eff == w_g) || g_empties) begin
        ptr_d    = (grant == LAST_VC) ? '0 : grant + 1'b1;
        credit_d = '0;
      end else begin
        ptr_d    = grant;
        credit_d = cred_eff + 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Control FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_INIT_WAIT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT_WAIT: begin
        if (init) state_d = ST_INIT;
      end
      ST_INIT: begin
        if (!init && enb) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (init)          state_d = ST_INIT;
        else if (push_req) state_d = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (init) begin
          state_d = ST_INIT;
        end else if (enb && all_empty && !out_valid_q && !push_req) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_INIT_WAIT;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      alto_q      <= '0;
      bajo_q      <= '0;
      weights_q   <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_vc_q    <= '0;
      ptr_q       <= '0;
      credit_q    <= '0;
      err_q       <= '0;
      pausa_q     <= '0;
      cont_q      <= '0;
    end else if (init_act) begin
      alto_q      <= umbral_alto;
      bajo_q      <= umbral_bajo;
      weights_q   <= weights;
      out_valid_q <= 1'b0;
      // FIFOs are flushed here, so the arbiter restarts from VC0.
      ptr_q       <= '0;
      credit_q    <= '0;
      err_q       <= '0;
      pausa_q     <= '0;
      cont_q      <= '0;
    end else if (run) begin
      err_q    <= err_q | drop_full;
      pausa_q  <= pausa_d;
      cont_q   <= cont_d;
      ptr_q    <= ptr_d;
      credit_q <= credit_d;
      if (pop) begin
        out_data_q  <= head_g;
        out_vc_q    <= grant;
        out_valid_q <= 1'b1;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign output_qos   = out_data_q;
  assign out_valid    = out_valid_q;
  assign out_vc       = out_vc_q;
  assign error_full   = err_q;
  assign pausa        = pausa_q;
  assign continue_qos = cont_q;
  assign idle_qos     = ((state_q == ST_IDLE) | (state_q == ST_ACTIVE)) & all_empty & ~out_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_qos_wrr.sv
`default_nettype none
// ============================================================================
//  Module      : tb_qos_wrr
//  Description : Self-checking bench for qos_wrr. A queue-based reference
//                model tracks FIFOs, WRR turns, output stage and flags; the
//                DUT is compared against it every cycle, plus directed checks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_qos_wrr;

  localparam int DW = 4, NV = 4, VB = 2, DL = 3, WW = 2;
  localparam int DEPTH = 1 << DL;
  localparam int CW = DL + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, enb, init, in_valid, out_ready;
  logic [CW-1:0]     umbral_alto, umbral_bajo;
  logic [NV*WW-1:0]  weights;
  logic [VB-1:0]     vc_id;
  logic [DW-1:0]     input_qos;
  logic [DW-1:0]     output_qos;
  logic              out_valid;
  logic [VB-1:0]     out_vc;
  logic [NV-1:0]     error_full, pausa, continue_qos;
  logic              idle_qos;

  qos_wrr #(
    .DATA_WIDTH (DW), .NUM_VC (NV), .VC_BITS (VB), .DEPTH_LOG2 (DL), .WEIGHT_W (WW)
  ) dut (
    .clk (clk), .rst (rst), .enb (enb), .init (init),
    .umbral_alto (umbral_alto), .umbral_bajo (umbral_bajo), .weights (weights),
    .in_valid (in_valid), .vc_id (vc_id), .input_qos (input_qos),
    .out_ready (out_ready), .output_qos (output_qos), .out_valid (out_valid),
    .out_vc (out_vc), .error_full (error_full), .pausa (pausa),
    .continue_qos (continue_qos), .idle_qos (idle_qos)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    else n_pass++;
  endtask

  // ---------------------------- reference model ----------------------------
  logic [DW-1:0] mq [NV][$];
  int            m_st;          // 0 wait-init, 1 init, 2 idle, 3 active
  int            m_alto, m_bajo;
  int            m_w [NV];
  bit            m_ov;
  logic [DW-1:0] m_od;
  int            m_ovc;
  logic [NV-1:0] m_err, m_pa, m_co;
  int            m_ptr, m_turn;
  int            obs_q [$];

  task automatic model_step();
    int  pre [NV];
    int  g, j, t, n, nst;
    bit  push_ok, all0, newp;
    if (rst) begin
      for (int i = 0; i < NV; i++) begin mq[i].delete(); m_w[i] = 0; end
      m_st = 0; m_alto = 0; m_bajo = 0; m_ov = 0; m_od = '0; m_ovc = 0;
      m_err = '0; m_pa = '0; m_co = '0; m_ptr = 0; m_turn = 0;
      return;
    end
    if (init || m_st == 1) begin
      m_alto = int'(umbral_alto);
      m_bajo = int'(umbral_bajo);
      for (int i = 0; i < NV; i++) begin
        m_w[i] = int'(weights[i*WW +: WW]);
        mq[i].delete();
      end
      m_err = '0; m_pa = '0; m_co = '0; m_ov = 0; m_ptr = 0; m_turn = 0;
      if (init) m_st = 1;
      else if (enb) m_st = 2;
      return;
    end
    if (!enb || m_st < 2) return;

    all0 = 1;
    for (int i = 0; i < NV; i++) begin
      pre[i] = mq[i].size();
      if (pre[i] != 0) all0 = 0;
    end
    push_ok = in_valid && (int'(vc_id) < NV);
    nst = m_st;
    if (m_st == 2 && push_ok) nst = 3;
    else if (m_st == 3 && all0 && !m_ov && !push_ok) nst = 2;

    g = -1;
    if (!m_ov || out_ready) begin
      if (pre[m_ptr] > 0) g = m_ptr;
      else begin
        for (int k = 1; k < NV; k++) begin
          j = (m_ptr + k) % NV;
          if (g < 0 && pre[j] > 0) g = j;
        end
      end
      if (g >= 0) begin
        m_od = mq[g].pop_front(); m_ovc = g; m_ov = 1;
      end else if (out_ready) begin
        m_ov = 0;
      end
    end

    if (push_ok) begin
      if (pre[vc_id] == DEPTH) m_err[vc_id] = 1'b1;
      else mq[vc_id].push_back(input_qos);
    end

    if (g >= 0) begin
      t = (g == m_ptr) ? m_turn + 1 : 1;
      if (t == m_w[g] + 1 || mq[g].size() == 0) begin
        m_ptr = (g + 1) % NV; m_turn = 0;
      end else begin
        m_ptr = g; m_turn = t;
      end
    end

    for (int i = 0; i < NV; i++) begin
      n = mq[i].size();
      newp = (n >= m_alto) || (m_pa[i] && n > m_bajo);
      m_co[i] = m_pa[i] && (n <= m_bajo);
      m_pa[i] = newp;
    end
    m_st = nst;
  endtask

  function automatic bit model_idle();
    bit e;
    e = (m_st >= 2) && !m_ov;
    for (int i = 0; i < NV; i++) if (mq[i].size() != 0) e = 0;
    return e;
  endfunction

  task automatic compare_all();
    chk("out_valid",    out_valid,    m_ov);
    chk("out_vc",       out_vc,       m_ovc);
    chk("output_qos",   output_qos,   m_od);
    chk("error_full",   error_full,   m_err);
    chk("pausa",        pausa,        m_pa);
    chk("continue_qos", continue_qos, m_co);
    chk("idle_qos",     idle_qos,     model_idle());
  endtask

  // One clock: record an output handshake, advance model, compare after edge.
  task automatic tick();
    if (out_valid && out_ready && enb && !rst && !init) obs_q.push_back(int'(out_vc));
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  int exp_wrr [12] = '{0, 0, 0, 1, 0, 0, 0, 1, 1, 1, 1, 1};
  int cont_seen, vc2_cnt;
  bit prev_rst;

  initial begin
    rst = 1'b1; enb = 1'b1; init = 1'b0; in_valid = 1'b0; vc_id = '0;
    input_qos = '0; out_ready = 1'b0; umbral_alto = 4'd6; umbral_bajo = 4'd2;
    weights = '0;

    // Reset state
    repeat (2) tick();
    chk("rst_out_valid",  out_valid,  0);
    chk("rst_output_qos", output_qos, 0);
    chk("rst_pausa",      pausa,      0);
    chk("rst_error_full", error_full, 0);
    chk("rst_idle",       idle_qos,   0);

    // Init, then idle once init drops
    rst = 1'b0; init = 1'b1;
    tick(); tick();
    init = 1'b0;
    tick();
    chk("idle_after_init", idle_qos, 1);

    // Plain round robin with weights 0; two-cycle push-to-valid latency
    out_ready = 1'b1; obs_q.delete();
    for (int v = 0; v < NV; v++) begin
      in_valid = 1'b1; vc_id = VB'(v); input_qos = DW'(v + 5);
      tick();
      if (v == 0) chk("latency_cycle1", out_valid, 0);
      if (v == 1) chk("latency_cycle2", out_valid, 1);
    end
    in_valid = 1'b0;
    repeat (6) tick();
    chk("rr_count", obs_q.size(), 4);
    for (int i = 0; i < obs_q.size() && i < 4; i++) chk("rr_order", obs_q[i], i);

    // Weighted: VC0 weight 2, VC1 weight 0, six words each
    init = 1'b1; weights = 8'b00_00_00_10;
    tick();
    init = 1'b0;
    tick();
    out_ready = 1'b0; obs_q.delete();
    for (int i = 0; i < 12; i++) begin
      in_valid = 1'b1;
      vc_id = (i < 6) ? 2'd0 : 2'd1;
      input_qos = (i < 6) ? DW'(i + 1) : DW'(i + 3);
      tick();
    end
    in_valid = 1'b0;
    // Back-pressure: output must hold the first VC0 word
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_valid", out_valid,  1);
      chk("hold_data",  output_qos, 1);
      chk("hold_vc",    out_vc,     0);
    end
    out_ready = 1'b1;
    repeat (20) tick();
    chk("wrr_count", obs_q.size(), 12);
    for (int i = 0; i < obs_q.size() && i < 12; i++) chk("wrr_order", obs_q[i], exp_wrr[i]);
    chk("idle_after_drain", idle_qos, 1);

    // Overflow / pausa / continue on VC2, output stage blocked by a VC0 word
    init = 1'b1; weights = '0;
    tick();
    init = 1'b0;
    tick();
    out_ready = 1'b0; in_valid = 1'b1; vc_id = 2'd0; input_qos = 4'hA;
    tick();
    in_valid = 1'b0;
    tick();
    chk("blocker_valid", out_valid, 1);
    for (int n = 1; n <= 9; n++) begin
      in_valid = 1'b1; vc_id = 2'd2; input_qos = DW'(n);
      tick();
      chk("pausa2_fill", pausa[2],      (n >= 6));
      chk("err2_fill",   error_full[2], (n == 9));
    end
    in_valid = 1'b0; out_ready = 1'b1; obs_q.delete(); cont_seen = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (continue_qos[2]) begin
        cont_seen++;
        chk("pausa2_drop_with_cont", pausa[2], 0);
      end
    end
    vc2_cnt = 0;
    foreach (obs_q[i]) if (obs_q[i] == 2) vc2_cnt++;
    chk("cont2_pulses", cont_seen, 1);
    chk("drain_total",  obs_q.size(), 9);
    chk("drain_vc2",    vc2_cnt, 8);
    chk("err2_sticky",  error_full[2], 1);

    // Randomized traffic against the model
    prev_rst = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      rst  = ($urandom_range(0, 999) == 0);
      init = prev_rst || ($urandom_range(0, 199) == 0);
      if (init) begin
        umbral_alto = CW'($urandom_range(1, 8));
        umbral_bajo = CW'($urandom_range(0, int'(umbral_alto) - 1));
        weights     = (NV*WW)'($urandom);
      end
      enb       = ($urandom_range(0, 9) != 0);
      in_valid  = ($urandom_range(0, 9) < 6);
      vc_id     = VB'($urandom_range(0, NV - 1));
      input_qos = DW'($urandom);
      out_ready = ($urandom_range(0, 1) == 1);
      prev_rst  = rst;
      tick();
    end

    // Reset in the middle of traffic
    rst = 1'b1; init = 1'b0; enb = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    tick();
    rst = 1'b0; init = 1'b1; umbral_alto = 4'd6; umbral_bajo = 4'd2; weights = '0;
    tick();
    init = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; vc_id = 2'd1; input_qos = DW'(i + 3);
      tick();
    end
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    chk("mrst_out_valid",  out_valid,  0);
    chk("mrst_output_qos", output_qos, 0);
    chk("mrst_out_vc",     out_vc,     0);
    chk("mrst_pausa",      pausa,      0);
    chk("mrst_idle",       idle_qos,   0);
    rst = 1'b0; init = 1'b1;
    tick();
    init = 1'b0; out_ready = 1'b1;
    tick();
    chk("mrst_empty_idle", idle_qos, 1);
    repeat (3) tick();
    chk("mrst_no_output", out_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
